// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter signals shared by the arbiter and its environment.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_send;
   logic                 tx_sending;
   logic [NUM_REQ-1:0]   grant;
   logic                 busy;
   logic                 timeout_err;
   modport master(input req_valid, req_data, tx_sending,
                  output req_ready, tx_data, tx_send, grant, busy, timeout_err);
   modport slave(output req_valid, req_data, tx_sending,
                 input req_ready, tx_data, tx_send, grant, busy, timeout_err);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one byte transmitter among NUM_REQ requesters, one byte per grant.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 15
) (
   input logic clk,
   input logic rst,
   uart_tx_arbiter_if.master bus
);
   localparam int PW = $clog2(NUM_REQ);
   localparam int CW = $clog2(START_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, SEND_HI, WAIT_START, BUSY} state_t;
   state_t        state;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] win;
   logic [CW-1:0] cnt;
   logic          found;
   logic          accept;
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
            win   = PW'((int'(rr_ptr) + i) % NUM_REQ);
            found = 1'b1;
         end
      end
   end
   // A frame still on the line (e.g. after a reset mid-frame) blocks new sends.
   assign accept        = (state == IDLE) && found && !bus.tx_sending && !rst;
   assign bus.req_ready = accept ? NUM_REQ'(1) << win : '0;
   assign bus.busy      = state != IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         rr_ptr          <= '0;
         cnt             <= '0;
         bus.tx_data     <= 8'h00;
         bus.tx_send     <= 1'b0;
         bus.grant       <= '0;
         bus.timeout_err <= 1'b0;
      end else begin
         bus.tx_send     <= 1'b0;
         bus.timeout_err <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               bus.tx_data <= bus.req_data[8*int'(win) +: 8];
               bus.grant   <= NUM_REQ'(1) << win;
               rr_ptr      <= PW'((int'(win) + 1) % NUM_REQ);
               bus.tx_send <= 1'b1;
               state       <= SEND_HI;
            end
            SEND_HI: begin
               cnt   <= '0;
               state <= WAIT_START;
            end
            WAIT_START: if (bus.tx_sending) begin
               cnt   <= '0;
               state <= BUSY;
            end else if (cnt == CW'(START_TIMEOUT - 1)) begin
               // Byte was already acked; it is dropped.
               cnt             <= '0;
               bus.timeout_err <= 1'b1;
               bus.grant       <= '0;
               state           <= IDLE;
            end else begin
               cnt <= cnt + 1'b1;
            end
            BUSY: if (!bus.tx_sending) begin
               bus.grant <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed checks of uart_tx_arbiter against a transaction-level model
// and a 5 Mbaud transmitter model (10 clocks per bit) that reads tx_data live.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int ST = 15;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;
   uart_tx_arbiter_if #(.NUM_REQ(N)) bus();
   uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(ST)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n_chk = 0;
   int n_err = 0;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask
   // Requesters: per-requester byte FIFOs, popped when ready is seen.
   logic [7:0]         qb[N][8];
   int                 qn[N];
   logic [N-1:0]       v = '0;
   logic [8*N-1:0]     d = '0;
   logic [N-1:0]       acked = '0;
   assign bus.req_valid = v;
   assign bus.req_data  = d;
   task automatic push(int i, logic [7:0] b);
      if (qn[i] < 8) begin
         qb[i][qn[i]] = b;
         qn[i]++;
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acked[i] && qn[i] > 0) begin
            for (int k = 1; k < 8; k++) qb[i][k-1] = qb[i][k];
            qn[i]--;
         end
      end
      acked = '0;
      for (int i = 0; i < N; i++) begin
         v[i]        = qn[i] > 0;
         d[8*i +: 8] = qn[i] > 0 ? qb[i][0] : 8'h00;
      end
   endtask
   // Transmitter: starts on the send falling edge, 10 bits of 10 clocks; stub mode never starts.
   logic stub = 1'b0;
   logic send_q = 1'b0;
   logic sending = 1'b0;
   int   bitn = 0;
   int   div = 0;
   logic line;
   assign bus.tx_sending = sending;
   assign line = !sending ? 1'b1 : bitn == 0 ? 1'b0 : bitn == 9 ? 1'b1 : bus.tx_data[bitn-1];
   always @(posedge clk) begin
      send_q <= bus.tx_send;
      if (!sending) begin
         if (!stub && send_q === 1'b1 && bus.tx_send === 1'b0) begin
            sending <= 1'b1;
            bitn    <= 0;
            div     <= 0;
         end
      end else if (div == 9) begin
         div <= 0;
         if (bitn == 9) sending <= 1'b0;
         else bitn <= bitn + 1;
      end else begin
         div <= div + 1;
      end
   end
   // Reference model: frame lifetime derived from the latency rules, not from the DUT.
   function automatic int pick(int p, logic [N-1:0] rv);
      for (int k = 0; k < N; k++) if (rv[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction
   logic       mon_en = 1'b0;
   logic       scb_en = 1'b0;
   logic       b2b = 1'b0;
   logic       m_fly = 1'b0;
   logic       m_started = 1'b0;
   logic       m_to = 1'b0;
   logic [7:0] m_data = 8'h00;
   int         m_ptr = 0, m_age = 0, m_own = 0;
   int         cyc = 0, acc_cyc = 0, to_cyc = -1, fall_cyc = -1;
   logic       prev_sending = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [9:0] fb = '0;
   logic [9:0] last_frame = '0;
   logic [7:0] exp_bytes[$];
   int         order[$];
   always @(negedge clk) if (mon_en) begin
      int           w;
      logic [N-1:0] er;
      logic         to_n;
      logic [7:0]   rb;
      w  = pick(m_ptr, bus.req_valid);
      er = (!m_fly && !rst && w >= 0 && !bus.tx_sending) ? N'(1) << w : '0;
      chk("req_ready", bus.req_ready, er);
      chk("tx_send", bus.tx_send, m_fly && m_age == 1);
      chk("grant", bus.grant, m_fly ? N'(1) << m_own : '0);
      chk("busy", bus.busy, m_fly);
      chk("timeout_err", bus.timeout_err, m_to);
      chk("tx_data", bus.tx_data, m_data);
      if (b2b && bus.tx_sending && prev_sending) chk("tx_data_stable", bus.tx_data, prev_data);
      if (b2b && prev_sending && !bus.tx_sending) fall_cyc = cyc;
      if (b2b && !prev_sending && bus.tx_sending && fall_cyc >= 0) chk("gap", cyc - fall_cyc, 4);
      if (bus.timeout_err) to_cyc = cyc;
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) order.push_back(i);
      acked = bus.req_ready;
      if (sending && div == 5) begin
         fb[9-bitn] = line;
         if (bitn == 9) begin
            last_frame = fb;
            for (int k = 0; k < 8; k++) rb[k] = fb[8-k];
            if (scb_en) begin
               chk("serial_pending", exp_bytes.size() > 0, 1);
               if (exp_bytes.size() > 0) chk("serial_byte", rb, exp_bytes.pop_front());
            end
         end
      end
      to_n = 1'b0;
      if (rst) begin
         m_fly  = 1'b0;
         m_ptr  = 0;
         m_data = 8'h00;
      end else if (er != 0) begin
         m_fly     = 1'b1;
         m_started = 1'b0;
         m_age     = 1;
         m_own     = w;
         m_ptr     = (w + 1) % N;
         m_data    = bus.req_data[8*w +: 8];
         acc_cyc   = cyc;
         if (scb_en) exp_bytes.push_back(m_data);
      end else if (m_fly) begin
         if (m_started) begin
            if (!bus.tx_sending) m_fly = 1'b0;
         end else if (m_age >= 2) begin
            if (bus.tx_sending) m_started = 1'b1;
            else if (m_age == ST + 1) begin
               m_fly = 1'b0;
               to_n  = 1'b1;
            end
         end
         m_age++;
      end
      m_to         = to_n;
      prev_sending = bus.tx_sending;
      prev_data    = bus.tx_data;
      cyc++;
   end
   task automatic reset_dut();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask
   task automatic drain(string tag, int budget);
      int n = 0;
      while ((qn[0] + qn[1] + qn[2] + qn[3] > 0 || bus.busy || sending) && n < budget) begin
         tick();
         n++;
      end
      chk(tag, n < budget, 1);
      repeat (3) tick();
   endtask
   initial begin
      int n;
      int exp2[5] = '{0, 1, 2, 3, 0};
      for (int i = 0; i < N; i++) qn[i] = 0;
      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
      reset_dut();
      // Single byte from requester 2
      scb_en = 1'b1;
      push(2, 8'hA5);
      drain("drain_single", 400);
      chk("single_frame", last_frame, 10'b0101001011);
      // Round robin with all four requesters
      reset_dut();
      order.delete();
      push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h14);
      drain("drain_rr", 1500);
      chk("rr_count", order.size(), 5);
      for (int k = 0; k < 5; k++) if (k < order.size()) chk("rr_order", order[k], exp2[k]);
      // Pointer wrap after requester 3
      push(3, 8'h33);
      drain("drain_wrap3", 400);
      order.delete();
      push(1, 8'h21); push(2, 8'h22);
      drain("drain_wrap", 800);
      chk("wrap_count", order.size(), 2);
      if (order.size() == 2) begin
         chk("wrap_first", order[0], 1);
         chk("wrap_second", order[1], 2);
      end
      // Start timeout with a dead transmitter
      scb_en = 1'b0;
      stub   = 1'b1;
      to_cyc = -1;
      push(0, 8'h5A);
      drain("drain_timeout", 100);
      chk("timeout_latency", to_cyc - acc_cyc, ST + 2);
      stub = 1'b0;
      // Reset in the middle of bit 3
      reset_dut();
      push(0, 8'h01); push(0, 8'h02); push(1, 8'h03);
      n = 0;
      while (!(sending && bitn == 3) && n < 300) begin
         tick();
         n++;
      end
      chk("reach_bit3", n < 300, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      order.delete();
      drain("drain_rst", 800);
      chk("rst_first_req", order.size() > 0 ? order[0] : -1, 0);
      // Back-to-back bytes from requester 1
      exp_bytes.delete();
      scb_en   = 1'b1;
      b2b      = 1'b1;
      fall_cyc = -1;
      order.delete();
      push(1, 8'hC1); push(1, 8'h3C); push(1, 8'h7E);
      drain("drain_b2b", 800);
      chk("b2b_count", order.size(), 3);
      b2b = 1'b0;
      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = int'($urandom_range(0, N - 1));
         if ($urandom_range(0, 7) == 0 && qn[r] < 2) push(r, 8'($urandom));
         tick();
      end
      drain("drain_random", 2500);
      chk("scoreboard_empty", exp_bytes.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
